// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for the two-requester data-memory arbiter: two word request/response
// ports plus the byte-wide memory side.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              req0_valid;
  logic              req0_we;
  logic [31:0]       req0_addr;
  logic [31:0]       req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [31:0]       rsp0_rdata;

  logic              req1_valid;
  logic              req1_we;
  logic [31:0]       req1_addr;
  logic [31:0]       req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [31:0]       rsp1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port word arbiter in front of a byte-wide big-endian data memory: grants one
// request, runs four byte beats, assembles load data and pulses a response.
module dmem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter bit RR_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]        state;
  logic [1:0]        beat;
  logic              lat_we;
  logic              lat_port;
  logic              last_grant;
  logic [ADDR_W-1:0] lat_base;
  logic [31:0]       lat_wdata;
  logic [23:0]       rd_acc;
  logic [31:0]       rsp0_rdata_q;
  logic [31:0]       rsp1_rdata_q;

  logic              grant;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_base;
  logic [31:0]       sel_wdata;
  logic              in_beat;
  logic [7:0]        beat_byte;

  // On a tie the round-robin pointer favours the port that did not win last time.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      grant = RR_EN ? ~last_grant : 1'b0;
    else if (bus.req1_valid)
      grant = 1'b1;
  end

  assign accept    = (state == IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
  assign sel_we    = grant ? bus.req1_we : bus.req0_we;
  assign sel_wdata = grant ? bus.req1_wdata : bus.req0_wdata;
  assign sel_base  = grant ? {bus.req1_addr[ADDR_W-3:0], 2'b00}
                           : {bus.req0_addr[ADDR_W-3:0], 2'b00};

  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  always_comb begin
    beat_byte = 8'h00;
    case (beat)
      2'd0: beat_byte = lat_wdata[31:24];
      2'd1: beat_byte = lat_wdata[23:16];
      2'd2: beat_byte = lat_wdata[15:8];
      2'd3: beat_byte = lat_wdata[7:0];
      default: beat_byte = 8'h00;
    endcase
  end

  assign in_beat       = ((state == WRITE) || (state == READ)) && !reset;
  assign bus.mem_en    = in_beat;
  assign bus.mem_we    = in_beat && (state == WRITE);
  assign bus.mem_addr  = in_beat ? (lat_base + ADDR_W'(beat)) : '0;
  assign bus.mem_wdata = (in_beat && (state == WRITE)) ? beat_byte : 8'h00;

  assign bus.busy       = (state != IDLE) && !reset;
  assign bus.rsp0_valid = (state == RESP) && !lat_port && !reset;
  assign bus.rsp1_valid = (state == RESP) && lat_port && !reset;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;

  // Read bytes arrive one cycle behind their beat, so byte k is shifted in while
  // beat k+1 is on the bus and the last one lands during DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      beat         <= 2'd0;
      lat_we       <= 1'b0;
      lat_port     <= 1'b0;
      last_grant   <= 1'b1;
      lat_base     <= '0;
      lat_wdata    <= 32'h0;
      rd_acc       <= 24'h0;
      rsp0_rdata_q <= 32'h0;
      rsp1_rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we     <= sel_we;
            lat_port   <= grant;
            last_grant <= grant;
            lat_base   <= sel_base;
            lat_wdata  <= sel_wdata;
            beat       <= 2'd0;
            state      <= sel_we ? WRITE : READ;
          end
        end
        WRITE: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            state <= RESP;
            if (lat_port) rsp1_rdata_q <= 32'h0;
            else          rsp0_rdata_q <= 32'h0;
          end
        end
        READ: begin
          beat <= beat + 2'd1;
          if (beat != 2'd0) rd_acc <= {rd_acc[15:0], bus.mem_rdata};
          if (beat == 2'd3) state <= DRAIN;
        end
        DRAIN: begin
          if (lat_port) rsp1_rdata_q <= {rd_acc, bus.mem_rdata};
          else          rsp0_rdata_q <= {rd_acc, bus.mem_rdata};
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter: one round-robin and one
// fixed-priority instance, each backed by a 256-byte memory model.
module tb_dmem_port_arbiter;
  logic clk;
  logic reset;

  int compared;
  int mismatched;

  dmem_port_arbiter_if #(.ADDR_W(8)) bus_a ();
  dmem_port_arbiter_if #(.ADDR_W(8)) bus_b ();

  dmem_port_arbiter #(.ADDR_W(8), .RR_EN(1'b1)) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  dmem_port_arbiter #(.ADDR_W(8), .RR_EN(1'b0)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  bit [7:0] mem_a [256];
  bit [7:0] mem_b [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memories: writes land at the edge, read data appears the following cycle.
  always @(posedge clk) begin
    if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
    bus_a.mem_rdata <= (bus_a.mem_en && !bus_a.mem_we) ? mem_a[bus_a.mem_addr] : 8'h00;
  end

  always @(posedge clk) begin
    if (bus_b.mem_en && bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
    bus_b.mem_rdata <= (bus_b.mem_en && !bus_b.mem_we) ? mem_b[bus_b.mem_addr] : 8'h00;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One full transaction on bus_a; request fields are scrambled after acceptance.
  task automatic applyStimulus(input bit port, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata);
    logic [7:0]  exp_addr;
    logic [31:0] shifted;
    @(negedge clk);
    if (port == 1'b0) begin
      bus_a.req0_valid = 1'b1; bus_a.req0_we = we;
      bus_a.req0_addr = addr;  bus_a.req0_wdata = wdata;
    end else begin
      bus_a.req1_valid = 1'b1; bus_a.req1_we = we;
      bus_a.req1_addr = addr;  bus_a.req1_wdata = wdata;
    end
    #1;
    checkOutput("ready_own", port ? bus_a.req1_ready : bus_a.req0_ready, 1);
    checkOutput("ready_other", port ? bus_a.req0_ready : bus_a.req1_ready, 0);
    @(negedge clk);
    if (port == 1'b0) begin
      bus_a.req0_valid = 1'b0; bus_a.req0_addr = ~addr; bus_a.req0_wdata = ~wdata;
    end else begin
      bus_a.req1_valid = 1'b0; bus_a.req1_addr = ~addr; bus_a.req1_wdata = ~wdata;
    end
    for (int k = 0; k < 4; k++) begin
      exp_addr = {addr[5:0], 2'b00} + 8'(k);
      shifted  = wdata >> (24 - 8 * k);
      checkOutput("beat_en", bus_a.mem_en, 1);
      checkOutput("beat_we", bus_a.mem_we, we);
      checkOutput("beat_addr", bus_a.mem_addr, exp_addr);
      checkOutput("beat_wdata", bus_a.mem_wdata, we ? shifted[7:0] : 8'h00);
      @(negedge clk);
    end
    if (!we) begin
      checkOutput("drain_en", bus_a.mem_en, 0);
      @(negedge clk);
    end
    checkOutput("rsp_own", port ? bus_a.rsp1_valid : bus_a.rsp0_valid, 1);
    checkOutput("rsp_other", port ? bus_a.rsp0_valid : bus_a.rsp1_valid, 0);
    checkOutput("rsp_rdata", port ? bus_a.rsp1_rdata : bus_a.rsp0_rdata, exp_rdata);
    checkOutput("resp_mem_en", bus_a.mem_en, 0);
    @(negedge clk);
    checkOutput("rsp_done", bus_a.rsp0_valid | bus_a.rsp1_valid, 0);
    checkOutput("idle_busy", bus_a.busy, 0);
  endtask

  int  cnt;
  int  cyc;
  bit  got [4];
  bit  seen;
  bit  found;

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    bus_a.req0_valid = 1'b0; bus_a.req0_we = 1'b0; bus_a.req0_addr = '0; bus_a.req0_wdata = '0;
    bus_a.req1_valid = 1'b0; bus_a.req1_we = 1'b0; bus_a.req1_addr = '0; bus_a.req1_wdata = '0;
    bus_b.req0_valid = 1'b0; bus_b.req0_we = 1'b0; bus_b.req0_addr = '0; bus_b.req0_wdata = '0;
    bus_b.req1_valid = 1'b0; bus_b.req1_we = 1'b0; bus_b.req1_addr = '0; bus_b.req1_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_busy", bus_a.busy, 0);
    checkOutput("rst_ready0", bus_a.req0_ready, 0);
    checkOutput("rst_rsp0", bus_a.rsp0_valid, 0);
    checkOutput("rst_mem_en", bus_a.mem_en, 0);
    checkOutput("rst_rdata0", bus_a.rsp0_rdata, 0);

    // Store then load through port 0, field changes after acceptance must not leak
    applyStimulus(1'b0, 1'b1, 32'd3, 32'h11223344, 32'h0);
    checkOutput("mem12", mem_a[12], 8'h11);
    checkOutput("mem13", mem_a[13], 8'h22);
    checkOutput("mem14", mem_a[14], 8'h33);
    checkOutput("mem15", mem_a[15], 8'h44);
    applyStimulus(1'b0, 1'b0, 32'd3, 32'h0, 32'h11223344);

    // Address wrap at the top of the 256-byte space
    applyStimulus(1'b0, 1'b1, 32'd63, 32'hA1B2C3D4, 32'h0);
    checkOutput("mem252", mem_a[252], 8'hA1);
    checkOutput("mem255", mem_a[255], 8'hD4);
    applyStimulus(1'b1, 1'b1, 32'd64, 32'h55667788, 32'h0);
    checkOutput("mem0", mem_a[0], 8'h55);
    checkOutput("mem3", mem_a[3], 8'h88);
    applyStimulus(1'b1, 1'b0, 32'd64, 32'h0, 32'h55667788);

    // Reset after two write beats abandons the store
    @(negedge clk);
    bus_a.req0_valid = 1'b1; bus_a.req0_we = 1'b1;
    bus_a.req0_addr = 32'd32; bus_a.req0_wdata = 32'hDEADBEEF;
    #1;
    checkOutput("abort_ready", bus_a.req0_ready, 1);
    @(negedge clk);
    bus_a.req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", bus_a.busy, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | bus_a.rsp0_valid | bus_a.rsp1_valid;
    end
    checkOutput("abort_no_rsp", seen, 0);
    checkOutput("abort_m128", mem_a[128], 8'hDE);
    checkOutput("abort_m129", mem_a[129], 8'hAD);
    checkOutput("abort_m130", mem_a[130], 8'h00);
    checkOutput("abort_m131", mem_a[131], 8'h00);
    applyStimulus(1'b0, 1'b1, 32'd32, 32'h01020304, 32'h0);
    checkOutput("after_m130", mem_a[130], 8'h03);

    // Round-robin: both ports valid continuously
    applyReset();
    @(negedge clk);
    bus_a.req0_valid = 1'b1; bus_a.req0_we = 1'b1; bus_a.req0_addr = 32'd10; bus_a.req0_wdata = 32'hAAAA0000;
    bus_a.req1_valid = 1'b1; bus_a.req1_we = 1'b1; bus_a.req1_addr = 32'd20; bus_a.req1_wdata = 32'hBBBB0000;
    #1;
    cnt = 0; cyc = 0;
    while (cnt < 4 && cyc < 200) begin
      if (bus_a.req0_ready || bus_a.req1_ready) begin
        checkOutput("rr_one_ready", bus_a.req0_ready & bus_a.req1_ready, 0);
        got[cnt] = bus_a.req1_ready;
        cnt++;
      end
      if (cnt < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    @(negedge clk);
    bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0;
    checkOutput("rr_count", cnt, 4);
    checkOutput("rr_g0", got[0], 0);
    checkOutput("rr_g1", got[1], 1);
    checkOutput("rr_g2", got[2], 0);
    checkOutput("rr_g3", got[3], 1);
    cyc = 0;
    while (bus_a.busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("rr_drain", bus_a.busy, 0);
    checkOutput("rr_mem41", mem_a[41], 8'hAA);
    checkOutput("rr_mem80", mem_a[80], 8'hBB);

    // Fixed priority: port 1 waits until port 0 drops valid
    @(negedge clk);
    bus_b.req0_valid = 1'b1; bus_b.req0_we = 1'b1; bus_b.req0_addr = 32'd5; bus_b.req0_wdata = 32'h01010101;
    bus_b.req1_valid = 1'b1; bus_b.req1_we = 1'b1; bus_b.req1_addr = 32'd6; bus_b.req1_wdata = 32'h02020202;
    #1;
    cnt = 0; cyc = 0;
    while (cnt < 3 && cyc < 200) begin
      if (bus_b.req0_ready || bus_b.req1_ready) begin
        got[cnt] = bus_b.req1_ready;
        cnt++;
      end
      if (cnt < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("fp_count", cnt, 3);
    checkOutput("fp_g0", got[0], 0);
    checkOutput("fp_g1", got[1], 0);
    checkOutput("fp_g2", got[2], 0);
    @(negedge clk);
    bus_b.req0_valid = 1'b0;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (bus_b.req1_ready) found = 1'b1;
    end
    checkOutput("fp_port1_served", found, 1);
    @(negedge clk);
    bus_b.req1_valid = 1'b0;
    cyc = 0;
    while (bus_b.busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("fp_drain", bus_b.busy, 0);
    checkOutput("fp_mem24", mem_b[24], 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
